// File: rtl/digit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : digit_pkg
// Description : Shared widths, segment codes and frame-state type for the
//               7-segment display-bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package digit_pkg;

    localparam int DG_W  = 11;
    localparam int SEG_W = 7;
    localparam int AN_W  = 4;

    // Blank segments with every digit enable deasserted (enables are active-low)
    localparam logic [DG_W-1:0] DG_BLANK = 11'h00F;

    // Segment patterns, gfedcba active-high
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    typedef enum logic [0:0] {
        FRAME_COLLECT = 1'b0,
        FRAME_COMMIT  = 1'b1
    } frame_state_t;

    // True when exactly one bit of the enable vector is set
    function automatic logic is_one_hot4(input logic [AN_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational 7-segment (gfedcba) to hex nibble decoder with
//               a legal-code flag. Shared with the digit driver's bench.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import digit_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             legal,
    output logic [3:0]       nibble
);

    // Map each of the sixteen hex glyphs back to its value; anything else is illegal
    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/digit_decode.sv
`default_nettype none
// ============================================================================
// Module      : digit_decode
// Description : Samples a multiplexed 7-segment display bus, waits for each
//               digit slot to settle, decodes it and reassembles the 16-bit
//               word. valid pulses once per complete four-digit frame.
//               Optional macro DIGIT_DECODE_STRICT_EN: an illegal segment
//               code at accept time pulses err and aborts the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_decode
    import digit_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [DG_W-1:0] dg_in,
    output logic [15:0]     data,
    output logic            valid,
    output logic            err,
    output logic [AN_W-1:0] seen
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [DG_W-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            taken_q, taken_d;
    logic [AN_W-1:0] seen_q, seen_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [15:0]     data_q, data_d;
    logic            err_q, err_d;
    frame_state_t    state_q, state_d;

    logic            seg_legal;
    logic [3:0]      seg_nibble;
    logic [AN_W-1:0] digit_sel;
    logic            accept;
    logic            frame_done;

    seg7_decode u_seg7_decode (
        .seg    (s2_q[DG_W-1:AN_W]),
        .legal  (seg_legal),
        .nibble (seg_nibble)
    );

    assign digit_sel = ~s2_q[AN_W-1:0];

    // A changed sample has priority over the counter, so a fresh value is
    // never accepted on the cycle it first appears
    assign accept = (s2_q == prev_q) && (cnt_q == CNT_MAX) && !taken_q
                    && is_one_hot4(digit_sel);

    // Two-flop synchronizer plus one-cycle history for change detection
    always_comb begin
        s1_d   = dg_in;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Stability counter: restart on any change, saturate once settled
    always_comb begin
        cnt_d   = cnt_q;
        taken_d = taken_q;
        if (s2_q != prev_q) begin
            cnt_d   = '0;
            taken_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (accept) begin
                taken_d = 1'b1;
            end
        end
    end

    // Digit capture into the shadow word and frame completion
    always_comb begin
        seen_d     = seen_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        err_d      = 1'b0;
        frame_done = 1'b0;
        if (accept) begin
            if (seg_legal) begin
                for (int i = 0; i < AN_W; i++) begin
                    if (digit_sel[i]) begin
                        shadow_d[i*4 +: 4] = seg_nibble;
                    end
                end
                seen_d = seen_q | digit_sel;
                if (seen_d == '1) begin
                    data_d     = shadow_d;
                    seen_d     = '0;
                    frame_done = 1'b1;
                end
            end
`ifdef DIGIT_DECODE_STRICT_EN
            else begin
                // Corrupt glyph: flag it and restart the frame, keep data
                err_d  = 1'b1;
                seen_d = '0;
            end
`endif
        end
    end

    // Frame FSM: COMMIT lasts exactly one cycle and drives valid
    always_comb begin
        state_d = state_q;
        case (state_q)
            FRAME_COLLECT: if (frame_done) state_d = FRAME_COMMIT;
            FRAME_COMMIT:  state_d = frame_done ? FRAME_COMMIT : FRAME_COLLECT;
            default:       state_d = FRAME_COLLECT;
        endcase
    end

    // State registers; sync flops reset to a blank, all-off bus
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q     <= DG_BLANK;
            s2_q     <= DG_BLANK;
            prev_q   <= DG_BLANK;
            cnt_q    <= '0;
            taken_q  <= 1'b0;
            seen_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            state_q  <= FRAME_COLLECT;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            taken_q  <= taken_d;
            seen_q   <= seen_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == FRAME_COMMIT);
    assign err   = err_q;
    assign seen  = seen_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_decode
// Description : Self-checking bench for digit_decode: table of digit holds,
//               hand-written corner sequences and randomized bus traffic,
//               all compared every cycle against a run-length based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_decode;

    localparam int S = 4;
`ifdef DIGIT_DECODE_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    localparam logic [10:0] BLANK = 11'h00F;

    logic        clk   = 1'b0;
    logic        nrst  = 1'b0;
    logic [10:0] dg_in = BLANK;
    logic [15:0] data;
    logic        valid;
    logic        err;
    logic [3:0]  seen;

    digit_decode #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .dg_in (dg_in),
        .data  (data),
        .valid (valid),
        .err   (err),
        .seen  (seen)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    logic [6:0] hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: bus as seen through two sample stages, and the
    // length of the current run of identical samples
    logic [10:0] m_s1, m_s2;
    int          m_run;
    logic [3:0]  m_seen;
    logic [15:0] m_shadow, m_data;
    logic        m_valid, m_err;

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (hex_seg[i] == s) return i;
        return -1;
    endfunction

    function automatic int slot_of(input logic [3:0] an_n);
        int n = 0;
        int k = -1;
        for (int i = 0; i < 4; i++) if (!an_n[i]) begin n++; k = i; end
        return (n == 1) ? k : -1;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = BLANK; m_s2 = BLANK; m_run = 2;
        m_seen = 4'h0; m_shadow = 16'h0; m_data = 16'h0;
        m_valid = 1'b0; m_err = 1'b0;
    endtask

    // A digit is taken when its value has sat in the second stage for
    // exactly S+1 consecutive samples
    task automatic model_edge();
        int sl;
        int d;
        m_valid = 1'b0;
        m_err   = 1'b0;
        sl = slot_of(m_s2[3:0]);
        if (m_run == S + 1 && sl >= 0) begin
            d = dec(m_s2[10:4]);
            if (d >= 0) begin
                m_shadow[sl*4 +: 4] = d[3:0];
                m_seen[sl] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_data  = m_shadow;
                    m_valid = 1'b1;
                    m_seen  = 4'h0;
                end
            end else if (STRICT) begin
                m_err  = 1'b1;
                m_seen = 4'h0;
            end
        end
        if (m_s1 == m_s2) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_s2 = m_s1;
        m_s1 = dg_in;
    endtask

    task automatic compare_all();
        check("seen",  {12'h0, seen},  {12'h0, m_seen});
        check("data",  data,           m_data);
        check("valid", {15'h0, valid}, {15'h0, m_valid});
        check("err",   {15'h0, err},   {15'h0, m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        valid_cnt += int'(valid);
        err_cnt   += int'(err);
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
        dg_in = {sg, an};
        repeat (n) tick();
    endtask

    task automatic do_reset(input int cycles);
        nrst  = 1'b0;
        dg_in = BLANK;
        model_reset();
        #1;
        compare_all();
        repeat (cycles) begin
            @(posedge clk);
            model_reset();
            #1;
            compare_all();
        end
        nrst = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  sg;
        logic [3:0]  exp_seen;
        logic [15:0] exp_data;
        int          exp_valid;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Overwrite then complete, mixed-in ignored patterns, then every glyph
        tbl.push_back('{4'hE, 7'h6D, 4'h1, 16'h0000, 0});
        tbl.push_back('{4'hE, 7'h6F, 4'h1, 16'h0000, 0});
        tbl.push_back('{4'hD, 7'h3F, 4'h3, 16'h0000, 0});
        tbl.push_back('{4'hB, 7'h3F, 4'h7, 16'h0000, 0});
        tbl.push_back('{4'h7, 7'h39, 4'h0, 16'hC009, 1});
        tbl.push_back('{4'hE, 7'h4F, 4'h1, 16'hC009, 0});
        tbl.push_back('{4'hD, 7'h5B, 4'h3, 16'hC009, 0});
        tbl.push_back('{4'h3, 7'h06, 4'h3, 16'hC009, 0});
        tbl.push_back('{4'hF, 7'h7F, 4'h3, 16'hC009, 0});
        tbl.push_back('{4'hB, 7'h06, 4'h7, 16'hC009, 0});
        tbl.push_back('{4'h7, 7'h3F, 4'h0, 16'h0123, 1});
        tbl.push_back('{4'hE, 7'h07, 4'h1, 16'h0123, 0});
        tbl.push_back('{4'hD, 7'h7D, 4'h3, 16'h0123, 0});
        tbl.push_back('{4'hB, 7'h6D, 4'h7, 16'h0123, 0});
        tbl.push_back('{4'h7, 7'h66, 4'h0, 16'h4567, 1});
        tbl.push_back('{4'hE, 7'h7C, 4'h1, 16'h4567, 0});
        tbl.push_back('{4'hD, 7'h77, 4'h3, 16'h4567, 0});
        tbl.push_back('{4'hB, 7'h6F, 4'h7, 16'h4567, 0});
        tbl.push_back('{4'h7, 7'h7F, 4'h0, 16'h89AB, 1});
        tbl.push_back('{4'hE, 7'h71, 4'h1, 16'h89AB, 0});
        tbl.push_back('{4'hD, 7'h79, 4'h3, 16'h89AB, 0});
        tbl.push_back('{4'hB, 7'h5E, 4'h7, 16'h89AB, 0});
        tbl.push_back('{4'h7, 7'h39, 4'h0, 16'hCDEF, 1});

        do_reset(2);

        for (int i = 0; i < tbl.size(); i++) begin
            valid_cnt = 0;
            hold(tbl[i].an, tbl[i].sg, 8);
            check("tbl_seen",  {12'h0, seen}, {12'h0, tbl[i].exp_seen});
            check("tbl_data",  data, tbl[i].exp_data);
            check("tbl_valid_pulses", 16'(valid_cnt), 16'(tbl[i].exp_valid));
        end

        // Illegal glyph on digit 2 with two digits already captured
        hold(4'hE, 7'h06, 8);
        hold(4'hD, 7'h5B, 8);
        check("pre_illegal_seen", {12'h0, seen}, 16'h0003);
        err_cnt = 0;
        hold(4'hB, 7'h00, 8);
        check("illegal_seen", {12'h0, seen}, STRICT ? 16'h0000 : 16'h0003);
        check("illegal_err_pulses", 16'(err_cnt), STRICT ? 16'd1 : 16'd0);
        check("illegal_data", data, 16'hCDEF);

        // Manual hold: accept lands on the 7th edge after the change
        do_reset(1);
        dg_in = {7'h06, 4'hE};
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("hold_seen", {12'h0, seen}, (k >= 7) ? 16'h0001 : 16'h0000);
        end

        // Four-cycle glitch on digit 3 must be discarded
        hold(4'h7, 7'h7F, 4);
        for (int k = 0; k < 10; k++) begin
            hold(4'hF, 7'h00, 1);
            check("glitch_seen", {12'h0, seen}, 16'h0001);
        end

        // Reset in the middle of a frame
        hold(4'hD, 7'h06, 8);
        check("pre_reset_seen", {12'h0, seen}, 16'h0003);
        valid_cnt = 0;
        do_reset(1);
        check("reset_seen", {12'h0, seen}, 16'h0000);
        check("reset_data", data, 16'h0000);
        hold(4'hF, 7'h00, 10);
        check("reset_valid_pulses", 16'(valid_cnt), 16'd0);

        // Randomized bus traffic with occasional resets
        for (int it = 0; it < 400; it++) begin
            logic [3:0] an;
            logic [6:0] sg;
            int         sel;
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 2));
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       an = 4'($urandom);
                1:       an = 4'hF;
                default: an = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 9) == 0) sg = 7'($urandom);
            else                           sg = hex_seg[$urandom_range(0, 15)];
            hold(an, sg, int'($urandom_range(1, 10)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_decode.md
# digit_decode

Receive-side counterpart of the multiplexed 7-segment digit driver: samples the 11-bit `{seg[6:0], an_n[3:0]}` display bus, waits for each digit slot to settle, decodes the segment pattern back to a hex nibble, and reassembles the 16-bit word. It is used for display loopback self-test and for capturing another board's display bus. `valid` pulses once per complete four-digit frame.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronized samples required before a digit is accepted. Legal range is 2..255.
- `clk`  in  1  system clock; the only clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `dg_in`  in  11  display bus. Bits [10:4] are the segments gfedcba, active-high. Bits [3:0] are the digit enables, active-low. Bit 3 selects nibble [15:12] and bit 0 selects nibble [3:0].
- `data`  out  16  last completed word. Held until the next frame completes.
- `valid`  out  1  one-cycle pulse on the cycle `data` updates.
- `err`  out  1  one-cycle pulse when an illegal segment pattern is accepted (strict builds only).
- `seen`  out  4  digits captured in the current frame, in the same bit order as `an_n`.

## Operation
- **Synchronizer:** 2-flop synchronizer on all 11 bits. Output `s2`; `prev` is `s2` delayed one cycle.
- **Stability counter:** 8-bit counter `cnt` and a `taken` flag.
  - If `s2 != prev`: `cnt <= 0`, `taken <= 0`.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES-1`.
- **Accept event:** occurs when `cnt == STABLE_CYCLES-1`, `taken == 0`, and `~s2[3:0]` is one-hot. It sets `taken`, so each stable hold is accepted exactly once.
- **Non-one-hot enables** (all off, or more than one on): never accepted, never an error. `seen` is unchanged.
- **Segment decode table** (segments to nibble):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F
  - Every other code is illegal.
- **On accepting a legal digit:** write the nibble into the 16-bit shadow slot for that digit and set its `seen` bit. If the digit was already seen, overwrite it; the latest value wins.
- **Frame completion:** when `seen` becomes 4'b1111, on that edge:
  - `data <= shadow` (including the nibble just accepted);
  - `valid <= 1` for one cycle;
  - `seen <= 0`.
- **Frame states:**
  - COLLECT: `seen` ≠ 1111, gathering digits.
  - COMMIT: one cycle, `valid` high.
  - Then back to COLLECT.
- No output backpressure. `valid` is informational only.

## Timing
- **Reset values:**
  - `data` = 0, `valid` = 0, `err` = 0, `seen` = 0, `cnt` = 0, `taken` = 0.
  - Sync flops and `prev` = 11'h00F (blank segments, all digits off).
- **Latency:** if `dg_in` changes before edge 1 and then holds, the accept (and the `seen`/`valid`/`err` update) lands on edge `STABLE_CYCLES + 3`.
- **Glitches:** a pattern shorter than `STABLE_CYCLES + 1` samples is discarded. This covers the driver's 2-cycle segment-versus-enable skew.
- **Reset mid-frame:** the partial frame is discarded and `data` clears to 0.
- **Same value on successive digits:** consecutive digits with identical segments still differ in `an_n`, so each one restarts the counter.

## Configuration
- `DIGIT_DECODE_STRICT_EN` defined:
  - An illegal code at an accept event pulses `err` for one cycle.
  - It also clears `seen`, aborting the frame.
  - The shadow and `data` are untouched.
- Not defined:
  - Illegal codes are ignored; no `seen` change.
  - `err` is tied to 0.

## Structure
- **Package `digit_pkg`:**
  - `SEG_0`..`SEG_F` 7-bit constants;
  - `DG_W` = 11, `SEG_W` = 7, `AN_W` = 4;
  - `DG_BLANK` = 11'h00F.
- **Sub-module `seg7_decode`:** combinational, `seg[6:0]` in, `{legal, nibble[3:0]}` out. The digit driver's testbench reuses it.

## Test plan
- **Loopback:** connect the digit driver with `data` = 16'h1A2F. Expect `data` = 16'h1A2F, with `valid` pulsing once per scan cycle and never with any other value.
- **Manual hold, default parameter:** hold `dg_in` = {0x06, 4'b1110} for 10 cycles. Expect `seen` = 4'b0001 at edge 7, then no further change.
- **Short glitch:** pulse `dg_in` = {0x7F, 4'b0111} for 4 cycles. Expect no accept, `seen` unchanged.
- **Strict illegal code:** with `seen` = 4'b0011, hold segments 0x00 on digit 2 in a strict build. Expect an `err` pulse, `seen` = 0, `data` unchanged. In a non-strict build, expect no `err` and `seen` = 4'b0011.
- **Overwrite then complete:** sequence digit0 = 5, digit0 = 9, then digits 1..3 = 0,0,C. Expect `data` = 16'hC009 and a single `valid` pulse.
- **Reset mid-frame:** assert `nrst` low for 1 cycle after two digits are accepted. Expect `seen` = 0, `data` = 0, `valid` never high.
